// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: byte-level SPI master (mode 0, MSB first) for the serial
// configuration flash. A data write starts one 8-bit exchange. A
// chip-select write drives cs_n under software control.
//
// Optional feature macro: SPI_FLASH_PREFETCH_EN
//   When defined, a read strobe in IDLE with the flash selected also starts
//   a transfer of 0xFF. This lets streaming reads use read strobes only.
//
// Parameters
//   DIV        SCK half-period in clk cycles (1..255)
// Ports
//   clk        system clock
//   resetq     asynchronous active-low reset
//   wr_i       data write strobe; starts a transfer of wd_i
//   cs_wr_i    chip-select write strobe; wd_i[0]=1 selects the flash
//   rd_i       data read strobe; clears done_o and ovr_o
//   wd_i       write data
//   miso_i     flash MISO
//   rx_data_o  last received byte
//   busy_o     transfer in progress
//   done_o     sticky: a byte completed since the last rd_i
//   ovr_o      sticky: wr_i arrived while busy
//   sck_o      flash SCK
//   mosi_o     flash MOSI
//   cs_n_o     flash chip select, active-low
module spi_flash_ctrl #(
    parameter int unsigned DIV = 2
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       wr_i,
    input  logic       cs_wr_i,
    input  logic       rd_i,
    input  logic [7:0] wd_i,
    input  logic       miso_i,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ovr_o,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       cs_n_o
);

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] shift_q;
    logic [7:0] div_q;
    logic [2:0] bit_q;
    logic [7:0] rx_q;
    logic       busy_q;
    logic       done_q;
    logic       ovr_q;
    logic       sck_q;
    logic       mosi_q;
    logic       cs_n_q;

    // Start request and byte to send when the block is idle
    logic       pf_start;
    logic       idle_start;
    logic [7:0] idle_byte;

`ifdef SPI_FLASH_PREFETCH_EN
    assign pf_start = rd_i && !cs_n_q;
`else
    assign pf_start = 1'b0;
`endif

    assign idle_start = wr_i || pf_start;
    assign idle_byte  = wr_i ? wd_i : 8'hFF;

    // Divider expiry and the final falling edge of a byte
    logic div_zero;
    logic last_fall;

    assign div_zero  = (div_q == 8'd0);
    assign last_fall = (state_q == ST_HIGH) && div_zero && (bit_q == 3'd7);

    // Transfer FSM with registered SPI pins and status flags
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            shift_q <= 8'h00;
            div_q   <= 8'h00;
            bit_q   <= 3'd0;
            rx_q    <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            // rd clears the sticky flags; a same-cycle set below overrides it
            if (rd_i) begin
                done_q <= 1'b0;
                ovr_q  <= 1'b0;
            end

            // A wr while busy is dropped, except on the last fall where it chains
            if ((state_q != ST_IDLE) && wr_i && !last_fall) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_wr_i) begin
                        cs_n_q <= ~wd_i[0];
                    end
                    if (idle_start) begin
                        state_q <= ST_LOW;
                        shift_q <= idle_byte;
                        mosi_q  <= idle_byte[7];
                        bit_q   <= 3'd0;
                        div_q   <= DIV_M1;
                        busy_q  <= 1'b1;
                    end
                end

                ST_LOW: begin
                    if (div_zero) begin
                        state_q <= ST_HIGH;
                        sck_q   <= 1'b1;
                        // mosi_q keeps the bit being sent; only the shift moves
                        shift_q <= {shift_q[6:0], miso_i};
                        div_q   <= DIV_M1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end

                ST_HIGH: begin
                    if (div_zero) begin
                        sck_q <= 1'b0;
                        div_q <= DIV_M1;
                        if (bit_q != 3'd7) begin
                            state_q <= ST_LOW;
                            mosi_q  <= shift_q[7];
                            bit_q   <= bit_q + 3'd1;
                        end else begin
                            rx_q   <= shift_q;
                            done_q <= 1'b1;
                            if (wr_i) begin
                                // Back-to-back byte with no idle cycle
                                state_q <= ST_LOW;
                                shift_q <= wd_i;
                                mosi_q  <= wd_i[7];
                                bit_q   <= 3'd0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    sck_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o = rx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ovr_o     = ovr_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;

endmodule
